// File: rtl/pool_layer_if.sv
// Row stream in from the conv array and pooled row stream out to the next layer.
// Direction names follow the pool_layer's point of view; the slave modport is the pool layer.
interface pool_layer_if #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6
);
    logic                              i_valid;
    logic [ARRAY_SIZE*WIDTH-1:0]       i_pixel_bus;
    logic                              o_ready;
    logic                              o_valid;
    logic [(ARRAY_SIZE/2)*WIDTH-1:0]   o_pool_bus;
    logic                              o_frame_end;
    logic                              i_ready;

    modport master (
        output i_valid, i_pixel_bus, i_ready,
        input  o_ready, o_valid, o_pool_bus, o_frame_end
    );

    modport slave (
        input  i_valid, i_pixel_bus, i_ready,
        output o_ready, o_valid, o_pool_bus, o_frame_end
    );
endinterface

// File: rtl/pool_layer.sv
// pool_layer: 2x2 signed max pooling over pairs of streamed conv output rows.
// Optional macro POOL_RELU_EN clamps negative pooled words to zero before the output register.
module pool_layer #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6,
    parameter int ROWS       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    pool_layer_if.slave io_bus
);
    localparam int OUT_SIZE = ARRAY_SIZE / 2;
    localparam int CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic S_EVEN = 1'b0;
    localparam logic S_ODD  = 1'b1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic                      r_state;
    logic [CNT_W-1:0]          r_row_cnt;
    logic [OUT_SIZE*WIDTH-1:0] r_buf;
    logic [OUT_SIZE*WIDTH-1:0] r_pool;
    logic                      r_valid;
    logic                      r_frame_end;

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_drain;
    logic [OUT_SIZE*WIDTH-1:0] w_hmax;
    logic [OUT_SIZE*WIDTH-1:0] w_pooled;

    function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] a);
`ifdef POOL_RELU_EN
        return a[WIDTH-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    always_comb begin
        w_hmax = '0;
        for (int j = 0; j < OUT_SIZE; j++) begin
            w_hmax[j*WIDTH +: WIDTH] = smax(io_bus.i_pixel_bus[(2*j)*WIDTH +: WIDTH],
                                            io_bus.i_pixel_bus[(2*j+1)*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        w_pooled = '0;
        for (int j = 0; j < OUT_SIZE; j++) begin
            w_pooled[j*WIDTH +: WIDTH] = clamp(smax(r_buf[j*WIDTH +: WIDTH],
                                                    w_hmax[j*WIDTH +: WIDTH]));
        end
    end

    // Even rows only fill the buffer, so they never wait on the output register.
    assign w_ready  = !rst_n && ((r_state == S_EVEN) || !r_valid || io_bus.i_ready);
    assign w_accept = io_bus.i_valid & w_ready;
    assign w_load   = w_accept & (r_state == S_ODD);
    assign w_drain  = r_valid & io_bus.i_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= S_EVEN;
            r_row_cnt   <= '0;
            r_buf       <= '0;
            r_pool      <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state   <= (r_state == S_EVEN) ? S_ODD : S_EVEN;
                r_row_cnt <= (r_row_cnt == LAST_ROW) ? '0 : r_row_cnt + 1'b1;
                if (r_state == S_EVEN) begin
                    r_buf <= w_hmax;
                end
            end
            if (w_load) begin
                r_pool      <= w_pooled;
                r_valid     <= 1'b1;
                r_frame_end <= (r_row_cnt == LAST_ROW);
            end else if (w_drain) begin
                r_valid     <= 1'b0;
                r_frame_end <= 1'b0;
            end
        end
    end

    assign io_bus.o_ready     = w_ready;
    assign io_bus.o_valid     = r_valid;
    assign io_bus.o_pool_bus  = r_pool;
    assign io_bus.o_frame_end = r_frame_end;
endmodule

// File: tb/tb_pool_layer.sv
// Randomised and directed bench for pool_layer against a row-pair max-pooling reference model.
module tb_pool_layer;
    localparam int WIDTH = 32;
    localparam int AS    = 6;
    localparam int OS    = AS / 2;
    localparam int ROWS  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pool_layer_if #(.WIDTH(WIDTH), .ARRAY_SIZE(AS)) bus_if ();

    pool_layer #(.WIDTH(WIDTH), .ARRAY_SIZE(AS), .ROWS(ROWS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string name, input logic [OS*WIDTH-1:0] act,
                             input logic [OS*WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int relu(input int a);
`ifdef POOL_RELU_EN
        return (a < 0) ? 0 : a;
`else
        return a;
`endif
    endfunction

    function automatic int word_of(input logic [AS*WIDTH-1:0] px, input int k);
        return int'($signed(px[k*WIDTH +: WIDTH]));
    endfunction

    function automatic logic [OS*WIDTH-1:0] pack3(input int a, input int b, input int c);
        logic [OS*WIDTH-1:0] r;
        r[0*WIDTH +: WIDTH] = a;
        r[1*WIDTH +: WIDTH] = b;
        r[2*WIDTH +: WIDTH] = c;
        return r;
    endfunction

    // Reference model: which row of the map is next, the horizontally pooled even row,
    // and the pooled beats loaded but not yet taken downstream.
    int                  m_idx;
    bit                  m_full;
    int                  hbuf[OS];
    logic [OS*WIDTH-1:0] m_q[$];
    bit                  m_fe[$];
    logic                m_ready;

    assign m_ready = !rst_n && (((m_idx % 2) == 0) || !m_full || bus_if.i_ready);

    function automatic logic [OS*WIDTH-1:0] expect_row(input logic [AS*WIDTH-1:0] px);
        logic [OS*WIDTH-1:0] r;
        for (int j = 0; j < OS; j++) begin
            r[j*WIDTH +: WIDTH] = relu(imax(hbuf[j],
                                            imax(word_of(px, 2*j), word_of(px, 2*j+1))));
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_idx  <= 0;
            m_full <= 1'b0;
            m_q.delete();
            m_fe.delete();
        end else begin
            if (m_full && bus_if.i_ready) begin
                m_q.delete(0);
                m_fe.delete(0);
            end
            if (bus_if.i_valid && m_ready) begin
                if ((m_idx % 2) == 0) begin
                    for (int j = 0; j < OS; j++) begin
                        hbuf[j] <= imax(word_of(bus_if.i_pixel_bus, 2*j),
                                        word_of(bus_if.i_pixel_bus, 2*j+1));
                    end
                end else begin
                    m_q.push_back(expect_row(bus_if.i_pixel_bus));
                    m_fe.push_back(m_idx == ROWS - 1);
                end
                m_idx <= (m_idx + 1) % ROWS;
            end
            m_full <= (m_full && !bus_if.i_ready) ||
                      (bus_if.i_valid && m_ready && ((m_idx % 2) == 1));
        end
    end

    always @(negedge clk) begin
        check_bit("o_ready", bus_if.o_ready, m_ready);
        check_bit("o_valid", bus_if.o_valid, m_full);
        if (m_full && m_q.size() != 0) begin
            check_bus("o_pool_bus", bus_if.o_pool_bus, m_q[0]);
            check_bit("o_frame_end", bus_if.o_frame_end, m_fe[0]);
        end
        if (rst_n) begin
            check_bus("reset_pool_bus", bus_if.o_pool_bus, '0);
            check_bit("reset_frame_end", bus_if.o_frame_end, 1'b0);
        end
    end

    // Beat counters observed straight off the DUT outputs.
    bit cnt_clr;
    int beats;
    int fe_beats;
    bit last_fe;

    always @(posedge clk) begin
        if (cnt_clr) begin
            beats    <= 0;
            fe_beats <= 0;
            last_fe  <= 1'b0;
        end else if (!rst_n && bus_if.o_valid && bus_if.i_ready) begin
            beats   <= beats + 1;
            last_fe <= bus_if.o_frame_end;
            if (bus_if.o_frame_end) fe_beats <= fe_beats + 1;
        end
    end

    // Called half a tick after a rising edge; returns half a tick after the accepting edge.
    task automatic send_row(input int r[AS]);
        bus_if.i_valid = 1'b1;
        for (int k = 0; k < AS; k++) bus_if.i_pixel_bus[k*WIDTH +: WIDTH] = r[k];
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus_if.o_ready) begin
                @(posedge clk);
                #1;
                bus_if.i_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: row not accepted within 50 cycles, required acceptance");
        bus_if.i_valid = 1'b0;
    endtask

    function automatic int rnd_word();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    logic [OS*WIDTH-1:0] held;

    initial begin
        bus_if.i_valid     = 1'b0;
        bus_if.i_pixel_bus = '0;
        bus_if.i_ready     = 1'b1;
        cnt_clr            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_o_ready", bus_if.o_ready, 1'b0);
        check_bit("reset_o_valid", bus_if.o_valid, 1'b0);
        check_bus("reset_o_pool_bus", bus_if.o_pool_bus, '0);
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;

        // Simple pair, one cycle latency.
        send_row('{1, 2, 3, 4, 5, 6});
        send_row('{6, 5, 4, 3, 2, 1});
        @(negedge clk);
        check_bit("basic_valid", bus_if.o_valid, 1'b1);
        check_bus("basic_bus", bus_if.o_pool_bus, pack3(6, 4, 6));
        check_bit("basic_fe", bus_if.o_frame_end, 1'b0);
        @(posedge clk);
        #1;

        // Negative words exercise the signed compare and the optional clamp.
        send_row('{-8, -3, -7, -9, -1, -2});
        send_row('{-4, -6, -10, -5, -2, -1});
        @(negedge clk);
`ifdef POOL_RELU_EN
        check_bus("neg_bus", bus_if.o_pool_bus, pack3(0, 0, 0));
`else
        check_bus("neg_bus", bus_if.o_pool_bus, pack3(-3, -5, -1));
`endif
        @(posedge clk);
        #1;

        // Last pair of the map carries frame_end.
        send_row('{7, 7, 7, 7, 7, 7});
        send_row('{7, 7, 0, 8, -1, 3});
        @(negedge clk);
        check_bus("last_bus", bus_if.o_pool_bus, pack3(7, 8, 7));
        check_bit("last_fe", bus_if.o_frame_end, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_int("frame_beats", beats, 3);
        check_int("frame_fe_beats", fe_beats, 1);
        check_bit("frame_fe_on_last", last_fe, 1'b1);

        // Backpressure: hold a beat, accept an even row, stall the odd row, then release.
        bus_if.i_ready = 1'b0;
        send_row('{0, 3, 8, 1, 4, 4});
        send_row('{5, 0, 2, 2, 9, 0});
        send_row('{10, 1, 5, 6, 0, 2});
        bus_if.i_valid = 1'b1;
        bus_if.i_pixel_bus = {32'd1, 32'd1, 32'd5, 32'd7, 32'd20, 32'd2};
        @(negedge clk);
        check_bit("bp_ready_low", bus_if.o_ready, 1'b0);
        held = bus_if.o_pool_bus;
        check_bus("bp_held", held, pack3(5, 8, 9));
        repeat (3) @(negedge clk);
        check_bus("bp_stable", bus_if.o_pool_bus, held);
        check_bit("bp_fe_clear", bus_if.o_frame_end, 1'b0);
        @(posedge clk);
        #1;
        bus_if.i_ready = 1'b1;
        @(negedge clk);
        check_bit("bp_ready_up", bus_if.o_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.i_valid = 1'b0;
        @(negedge clk);
        check_bit("bp_valid_kept", bus_if.o_valid, 1'b1);
        check_bus("bp_new_bus", bus_if.o_pool_bus, pack3(20, 7, 2));
        @(posedge clk);
        #1;

        // Reset after an even row must discard the buffered half row.
        send_row('{1, 2, 3, 4, 5, 6});
        rst_n = 1'b1;
        #1;
        check_bit("midreset_ready", bus_if.o_ready, 1'b0);
        check_bit("midreset_valid", bus_if.o_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        send_row('{9, 9, 9, 9, 9, 9});
        send_row('{1, 1, 1, 1, 1, 1});
        @(negedge clk);
        check_bus("midreset_bus", bus_if.o_pool_bus, pack3(9, 9, 9));
        check_bit("midreset_fe", bus_if.o_frame_end, 1'b0);
        @(posedge clk);
        #1;

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            rst_n          = ($urandom_range(0, 299) == 0);
            bus_if.i_valid = ($urandom_range(0, 9) < 7);
            bus_if.i_ready = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < AS; k++) bus_if.i_pixel_bus[k*WIDTH +: WIDTH] = rnd_word();
            @(posedge clk);
            #1;
        end
        rst_n          = 1'b0;
        bus_if.i_valid = 1'b0;
        bus_if.i_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_bit("drained_valid", bus_if.o_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pool_layer.md
POOL_LAYER -- requirements
Module: pool_layer

Interface
REQ-001 Parameter WIDTH, 32, bit width of one signed two's-complement feature word.
REQ-002 Parameter ARRAY_SIZE, 6, conv outputs per input row; SHALL be even.
REQ-003 Parameter ROWS, 6, conv output rows per feature map; SHALL be even.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-high reset; the port keeps the codebase name, and the asserted level is 1.
REQ-006 i_valid  input  1  upstream conv array presents a row on i_pixel_bus.
REQ-007 i_pixel_bus  input  ARRAY_SIZE*WIDTH  one conv output row; word k at bits [k*WIDTH +: WIDTH].
REQ-008 o_ready  output  1  pool_layer accepts the row this cycle.
REQ-009 o_valid  output  1  o_pool_bus holds a pooled row.
REQ-010 o_pool_bus  output  (ARRAY_SIZE/2)*WIDTH  pooled row; word j at bits [j*WIDTH +: WIDTH].
REQ-011 o_frame_end  output  1  qualifies the o_valid beat carrying the last pooled row of a map.
REQ-012 i_ready  input  1  downstream accepts o_pool_bus when o_valid&i_ready.

Function
REQ-013 A row SHALL be accepted exactly on cycles where i_valid&o_ready.
REQ-014 Horizontal stage: h[j] SHALL be the signed max of words 2j and 2j+1 of the accepted row.
REQ-015 FSM states: S_EVEN and S_ODD.
- S_EVEN: on accept, store h[] into a row buffer and go to S_ODD.
- S_ODD: on accept, load the output register with signed max(buffer[j], h[j]), set o_valid, and go to S_EVEN.
REQ-016 Latency SHALL be 1 cycle: o_valid rises on the edge following the odd-row accept.
REQ-017 o_ready SHALL be 1 in S_EVEN regardless of output state.
REQ-018 o_ready SHALL be (!o_valid | i_ready) in S_ODD; a drain and a new load may occur in the same cycle without a bubble.
REQ-019 o_valid SHALL clear on o_valid&i_ready unless a new load occurs in the same cycle; o_pool_bus SHALL stay stable while o_valid&!i_ready.
REQ-020 Row counter, 0..ROWS-1:
- increments on each accepted row;
- wraps to 0 after ROWS-1;
- o_frame_end SHALL be set with the load of the row accepted at count ROWS-1 and cleared with that beat's drain.
REQ-021 Equal operands SHALL yield that value; signed comparison SHALL be used throughout (e.g. max(-1, -5) = -1).
REQ-022 No arithmetic widening: output words SHALL be WIDTH bits, copied from an input word.

Reset
REQ-023 While rst_n=1, the following SHALL hold immediately (asynchronously):
- state = S_EVEN, row counter = 0;
- o_valid = 0, o_frame_end = 0;
- o_pool_bus = 0, row buffer = 0.
REQ-024 Reset mid-frame SHALL discard any buffered half row; the first row accepted after release is row 0 (even).
REQ-025 o_ready SHALL be 0 while rst_n=1.

Configuration
REQ-026 Macro POOL_RELU_EN:
- defined: each output word SHALL be clamped to 0 when negative (ReLU applied after pooling, before the output register);
- undefined: pooled values SHALL pass unmodified.
- Interface and latency SHALL be identical in both builds.

Verification
REQ-027 Row0 = {1,2,3,4,5,6}, Row1 = {6,5,4,3,2,1}, i_ready=1 -> one beat, o_pool_bus = {6,4,6} (word0 first), 1 cycle after Row1 accept.
REQ-028 Rows {-8,-3,-7,-9,-1,-2} and {-4,-6,-10,-5,-2,-1}:
- POOL_RELU_EN undefined -> {-3,-5,-1};
- POOL_RELU_EN defined -> {0,0,0}.
REQ-029 Six rows streamed back-to-back with i_ready=1 -> exactly 3 o_valid beats; o_frame_end=1 only on the third; the counter returns to 0.
REQ-030 i_ready held 0 after the first pooled beat:
- the next even row is accepted;
- o_ready=0 in S_ODD and o_pool_bus is stable;
- raising i_ready drains and loads in the same cycle.
REQ-031 rst_n pulsed high after Row0 only, then Row {9,9,9,9,9,9} and Row {1,1,1,1,1,1} -> output {9,9,9}, with no Row0 contribution.
